// File: rtl/serial_addsub_pkg.sv
// Shared types and limits for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/serial_addsub_full_adder_cell.sv
// One-bit full adder built from two half-adder stages joined by an OR.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic hs_sum;
    logic hs_carry;
    logic hc_carry;

    assign hs_sum   = a ^ b;
    assign hs_carry = a & b;
    assign sum      = hs_sum ^ cin;
    assign hc_carry = hs_sum & cin;
    assign cout     = hs_carry | hc_carry;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one full-adder cell plus a carry flop.
// Define SERIAL_ADDSUB_OVF_EN to add the signed-overflow output.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    full_adder_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (cy_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    cy_d    = sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {fa_sum, res_q[WIDTH-1:1]};
                cy_d  = fa_cout;
                cnt_d = cnt_q + CNT_W'(1);
                // On the last bit A[0]/B[0] hold the operand MSBs.
                if (cnt_q == LAST_CNT) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    carry_d = fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = (a_q[0] == b_q[0]) && (fa_sum != a_q[0]);
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign carry = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor that takes two WIDTH-bit operands, processes one bit per clock LSB-first through a single full-adder cell and a carry flip-flop, and reports sum, carry and optional signed overflow with a start/busy/done handshake. It succeeds the combinational one-bit adder cells in the arithmetic library. It serves area-constrained datapaths where WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..64.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only when not busy.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when sum, carry and ovf become valid.
- sum  out  WIDTH  result; holds until the next completion.
- carry  out  1  carry out of MSB; for sub, 1 = no borrow.
- ovf  out  1  signed overflow; present only with SERIAL_ADDSUB_OVF_EN.

## Operation
- States are IDLE, RUN and DONE.
- IDLE, start=1:
  - latch a into operand register A and (sub ? ~b : b) into operand register B;
  - carry flip-flop ← sub; bit counter ← 0; go to RUN.
- RUN, each cycle:
  - full-adder cell takes A[0], B[0] and the carry flip-flop;
  - the sum bit shifts into the MSB of an internal result shift register;
  - A and B shift right one bit; the carry flip-flop takes the cell's carry-out; counter increments.
- RUN, on the cycle the counter equals WIDTH−1:
  - copy the shifted result into sum;
  - final cell carry → carry;
  - compute ovf;
  - go to DONE.
- DONE lasts one cycle with done=1, then goes to IDLE. start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation.
- start while in RUN is ignored, with no queuing.
- Arithmetic is modulo 2^WIDTH. Subtraction is two's complement: a + ~b + 1.
- ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the possibly inverted b.
- sum, carry and ovf are stable between done pulses and are never updated mid-computation.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state ← IDLE; busy=0, done=0, sum=0, carry=0, ovf=0;
  - internal registers and counter are cleared;
  - applies mid-RUN: the computation is aborted and no done is issued.
- start sampled at edge k:
  - busy=1 from after edge k through edge k+WIDTH;
  - outputs updated and done=1 after edge k+WIDTH, i.e. latency is WIDTH cycles;
  - busy=0 in the DONE cycle.
- Throughput is one operation per WIDTH+1 cycles when start is held high continuously.
- All outputs are registered; no combinational input-to-output paths.
- rst_n has priority over start.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: the ovf port exists and is computed as above.
- SERIAL_ADDSUB_OVF_EN undefined:
  - the ovf port and its logic are absent;
  - all other behaviour and timing are identical.

## Structure
- Package serial_addsub_pkg holds:
  - the state typedef, encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - constants for the minimum and maximum WIDTH.
- The counter width is $clog2(WIDTH), derived locally.
- Sub-module full_adder_cell: combinational, ports a, b, cin, sum, cout. It is built from two half-adder stages plus an OR.
- One instance only.

## Test plan
All scenarios use WIDTH=8.
- 8'hFF + 8'h01, sub=0 → sum=8'h00, carry=1, ovf=0; done exactly 8 cycles after start.
- 8'h7F + 8'h01, sub=0 → sum=8'h80, carry=0, ovf=1.
- 8'h05 − 8'h07, sub=1 → sum=8'hFE, carry=0 (borrow), ovf=0.
- 8'h80 − 8'h01, sub=1 → sum=8'h7F, carry=1, ovf=1.
- Start 8'h10+8'h20, pulse start with 8'h01+8'h01 at cycle 3 → ignored; sum=8'h30. A start held in the DONE cycle launches the next operation immediately.
- rst_n low at cycle 4 of an operation → busy=0, done never pulses, all outputs 0. A new start afterwards completes correctly.
